stopwatch_ctrl: RTL and testbench

Control sequencer for the stopwatch seconds/minutes counter. Synchronizes and edge-detects the start/stop and lap/reset buttons, runs the run/stop/lap/clear state machine, and divides the system clock into the one-cycle count-enable pulse. It drives the counter's enable and clear inputs, and muxes live or lap-frozen digits to the display.

---
 rtl/stopwatch_ctrl.sv | 128 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button sync and edge detect, run/stop/lap/clear
// FSM, count-enable prescaler, and a live/lap display mux.
module stopwatch_ctrl #(
   parameter int TICK_DIV = 50000000
) (
   input  logic       CLK,
   input  logic       CLR,
   input  logic       STRTSTOP,
   input  logic       LAP_LOAD,
   input  logic [3:0] SEC_LSB_IN,
   input  logic [3:0] SEC_MSB_IN,
   input  logic [3:0] MINUTES_IN,
   output logic       CNT_CE,
   output logic       CNT_CLR,
   output logic [3:0] DISP_SEC_LSB,
   output logic [3:0] DISP_SEC_MSB,
   output logic [3:0] DISP_MINUTES,
   output logic       RUN_ACTIVE,
   output logic       LAP_ACTIVE
);

   localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      CLEARED  = 2'd0,
      RUNNING  = 2'd1,
      STOPPED  = 2'd2,
      LAP_HOLD = 2'd3
   } state_t;

   state_t        state, state_next;
   logic [2:0]    start_sync, lap_sync;
   logic          start_press, lap_press;
   logic          lap_capture;
   logic [PW-1:0] presc;
   logic [3:0]    lap_sec_lsb, lap_sec_msb, lap_minutes;

   // Three-stage button path [s3 s2 s1]; presetting to all-ones means a button
   // held through reset looks "already pressed" and needs a release first.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours, which is what makes a shift chain work.
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         start_sync <= 3'b111;
         lap_sync   <= 3'b111;
      end else begin
         start_sync <= {start_sync[1:0], STRTSTOP};
         lap_sync   <= {lap_sync[1:0], LAP_LOAD};
      end
   end

   assign start_press = start_sync[1] & ~start_sync[2];
   assign lap_press   = lap_sync[1] & ~lap_sync[2];

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) state <= CLEARED;
      else     state <= state_next;
   end

   // NOTE: state_next gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      unique case (state)
         CLEARED:  if (start_press) state_next = RUNNING;
         RUNNING:  if (start_press) state_next = STOPPED;
                   else if (lap_press) state_next = LAP_HOLD;
         LAP_HOLD: if (start_press) state_next = STOPPED;
                   else if (lap_press) state_next = RUNNING;
         STOPPED:  if (start_press) state_next = RUNNING;
                   else if (lap_press) state_next = CLEARED;
         default:  state_next = CLEARED;
      endcase
   end

   assign lap_capture = (state == RUNNING) && (state_next == LAP_HOLD);

   // The lap registers have a defined reset value because they are visible on
   // the display as soon as LAP_HOLD is entered.
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         lap_sec_lsb <= 4'd0;
         lap_sec_msb <= 4'd0;
         lap_minutes <= 4'd0;
      end else if (lap_capture) begin
         lap_sec_lsb <= SEC_LSB_IN;
         lap_sec_msb <= SEC_MSB_IN;
         lap_minutes <= MINUTES_IN;
      end
   end

   // Prescaler keys off the current state, so a wrap on the edge that leaves
   // RUNNING still emits its pulse; STOPPED holds the sub-tick fraction.
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         presc  <= '0;
         CNT_CE <= 1'b0;
      end else begin
         CNT_CE <= 1'b0;
         unique case (state)
            CLEARED: presc <= '0;
            RUNNING, LAP_HOLD: begin
               if (presc == LAST) begin
                  presc  <= '0;
                  CNT_CE <= 1'b1;
               end else begin
                  presc <= presc + PW'(1);
               end
            end
            default: presc <= presc;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) CNT_CLR <= 1'b1;
      else     CNT_CLR <= (state_next == CLEARED);
   end

   assign RUN_ACTIVE = (state == RUNNING) || (state == LAP_HOLD);
   assign LAP_ACTIVE = (state == LAP_HOLD);

   assign DISP_SEC_LSB = LAP_ACTIVE ? lap_sec_lsb : SEC_LSB_IN;
   assign DISP_SEC_MSB = LAP_ACTIVE ? lap_sec_msb : SEC_MSB_IN;
   assign DISP_MINUTES = LAP_ACTIVE ? lap_minutes : MINUTES_IN;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV = 4; expected values are
// hand-derived from the button latency and prescaler timing.
module tb_stopwatch_ctrl;

   logic       clk = 1'b0;
   logic       clr;
   logic       strtstop;
   logic       lap_load;
   logic [3:0] sec_lsb_in, sec_msb_in, minutes_in;
   logic       cnt_ce, cnt_clr, run_active, lap_active;
   logic [3:0] disp_sec_lsb, disp_sec_msb, disp_minutes;

   int total_cnt  = 0;
   int passed_cnt = 0;
   int ce_seen;

   stopwatch_ctrl #(.TICK_DIV(4)) dut (
      .CLK          (clk),
      .CLR          (clr),
      .STRTSTOP     (strtstop),
      .LAP_LOAD     (lap_load),
      .SEC_LSB_IN   (sec_lsb_in),
      .SEC_MSB_IN   (sec_msb_in),
      .MINUTES_IN   (minutes_in),
      .CNT_CE       (cnt_ce),
      .CNT_CLR      (cnt_clr),
      .DISP_SEC_LSB (disp_sec_lsb),
      .DISP_SEC_MSB (disp_sec_msb),
      .DISP_MINUTES (disp_minutes),
      .RUN_ACTIVE   (run_active),
      .LAP_ACTIVE   (lap_active)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic set_live(input logic [3:0] lsb, input logic [3:0] msb, input logic [3:0] mins);
      sec_lsb_in = lsb;
      sec_msb_in = msb;
      minutes_in = mins;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total_cnt++;
      assert (observed === expected) passed_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
   endtask

   task automatic ce_count(input int n, output int c);
      c = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (cnt_ce === 1'b1) c++;
      end
   endtask

   function automatic logic [11:0] disp();
      return {disp_minutes, disp_sec_msb, disp_sec_lsb};
   endfunction

   initial begin
      clr = 1'b1; strtstop = 1'b0; lap_load = 1'b0;
      set_live(4'd3, 4'd2, 4'd1);
      #3;
      check("rst_ce",   cnt_ce, 0);
      check("rst_clr",  cnt_clr, 1);
      check("rst_run",  run_active, 0);
      check("rst_lap",  lap_active, 0);
      check("rst_disp", disp(), 12'h123);
      ticks(2);
      clr = 1'b0;
      tick();

      // Start from CLEARED: state moves on the third edge after the level rises.
      strtstop = 1'b1;
      ticks(2);
      check("start_lat_run", run_active, 0);
      check("start_lat_clr", cnt_clr, 1);
      tick();
      check("start_run", run_active, 1);
      check("start_clr", cnt_clr, 0);
      strtstop = 1'b0;
      ticks(3);
      check("ce_before_first", cnt_ce, 0);
      tick();
      check("ce_first", cnt_ce, 1);
      tick();
      check("ce_first_end", cnt_ce, 0);
      ce_count(35, ce_seen);
      check("ce_run_count", ce_seen, 9);

      // Stop with prescaler at 3, then resume: first pulse one cycle later.
      strtstop = 1'b1;
      ticks(3);
      check("stop_run", run_active, 0);
      strtstop = 1'b0;
      ce_count(8, ce_seen);
      check("stopped_ce", ce_seen, 0);
      strtstop = 1'b1;
      ticks(3);
      check("resume_run", run_active, 1);
      check("resume_ce_pre", cnt_ce, 0);
      strtstop = 1'b0;
      tick();
      check("resume_ce_early", cnt_ce, 1);
      tick();
      check("resume_ce_end", cnt_ce, 0);

      // Lap while running: display frozen, counting continues.
      lap_load = 1'b1;
      ticks(3);
      check("lap_active", lap_active, 1);
      check("lap_run", run_active, 1);
      check("lap_ce", cnt_ce, 1);
      check("lap_disp", disp(), 12'h123);
      lap_load = 1'b0;
      set_live(4'd4, 4'd5, 4'd6);
      ce_count(8, ce_seen);
      check("lap_ce_count", ce_seen, 2);
      check("lap_frozen", disp(), 12'h123);
      lap_load = 1'b1;
      ticks(3);
      check("unlap_lap", lap_active, 0);
      check("unlap_run", run_active, 1);
      check("unlap_disp", disp(), 12'h654);
      lap_load = 1'b0;
      tick();
      check("ce_after_unlap", cnt_ce, 1);

      // Stop, then lap clears.
      strtstop = 1'b1;
      ticks(3);
      check("stop2_run", run_active, 0);
      check("stop2_clr", cnt_clr, 0);
      strtstop = 1'b0;
      ticks(3);
      lap_load = 1'b1;
      ticks(2);
      check("clear_lat_clr", cnt_clr, 0);
      tick();
      check("clear_clr", cnt_clr, 1);
      check("clear_run", run_active, 0);
      check("clear_lap", lap_active, 0);
      lap_load = 1'b0;
      ticks(3);

      // Restart from CLEARED: a full four-cycle wait proves the prescaler was zeroed.
      strtstop = 1'b1;
      ticks(3);
      check("restart_run", run_active, 1);
      check("restart_clr", cnt_clr, 0);
      strtstop = 1'b0;
      ticks(3);
      check("restart_ce_pre", cnt_ce, 0);
      tick();
      check("restart_ce", cnt_ce, 1);

      // Simultaneous start and lap from RUNNING: start wins.
      strtstop = 1'b1;
      lap_load = 1'b1;
      ticks(3);
      check("simul_run", run_active, 0);
      check("simul_lap", lap_active, 0);
      check("simul_disp", disp(), 12'h654);
      strtstop = 1'b0;
      lap_load = 1'b0;
      tick();

      // Button held through CLR is ignored until released and pressed again.
      clr = 1'b1;
      #1;
      check("clr_async_clr", cnt_clr, 1);
      strtstop = 1'b1;
      ticks(2);
      clr = 1'b0;
      ticks(5);
      check("held_ignored", run_active, 0);
      strtstop = 1'b0;
      ticks(3);
      strtstop = 1'b1;
      ticks(3);
      check("press_after_release", run_active, 1);
      strtstop = 1'b0;

      // CLR during LAP_HOLD while a count pulse is high.
      set_live(4'd7, 4'd8, 4'd9);
      ticks(3);
      lap_load = 1'b1;
      ticks(3);
      check("lap2_active", lap_active, 1);
      lap_load = 1'b0;
      set_live(4'd0, 4'd1, 4'd2);
      tick();
      check("lap2_frozen", disp(), 12'h987);
      for (int i = 0; i < 8 && cnt_ce !== 1'b1; i++) tick();
      check("ce_before_clr", cnt_ce, 1);
      #2;
      clr = 1'b1;
      #1;
      check("clr_mid_ce",   cnt_ce, 0);
      check("clr_mid_clr",  cnt_clr, 1);
      check("clr_mid_lap",  lap_active, 0);
      check("clr_mid_run",  run_active, 0);
      check("clr_mid_disp", disp(), 12'h210);

      $display("%0d/%0d checks passed", passed_cnt, total_cnt);
      $finish;
   end

endmodule
